spmv_row_reduce: RTL
====================

Name: spmv_row_reduce

Overview:
- Downstream neighbour of the SpMV parallel multiplier stage.
- Consumes PARALLELISM signed integer products per beat and reduces the lanes with a registered adder tree.
- Accumulates beats until the row-end marker, then emits one row dot-product result over a valid/ready handshake to the result writer.
- Integer (non-FLOAT) datapath only.

Parameters:
- DATA_WIDTH, 64: width of each incoming product (signed, two's complement).
- PARALLELISM, 4: lanes per beat; must be >= 1.
- ACC_WIDTH, 72: accumulator and result width; must be >= DATA_WIDTH + clog2(PARALLELISM).
- ROW_WIDTH, 16: width of the emitted row index counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  [DATA_WIDTH-1:0] x PARALLELISM (unpacked array)  lane products.
- in_mask  in  PARALLELISM  per-lane enable; a masked-off lane contributes 0.
- in_last  in  1  this beat ends the current row.
- out_valid  out  1  row result valid.
- out_ready  in  1  consumer ready.
- out_data  out  ACC_WIDTH  signed row sum.
- out_row  out  ROW_WIDTH  index of the row in out_data, counting from 0.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_row=0.
  - Accumulator=0, row counter=0, all pipeline valid bits=0.
  - in_ready=1 once reset is released.
- Pipeline enable: en = !out_valid || out_ready; in_ready = en.
  - When en=0, every stage holds its contents. No beat is dropped or duplicated.
- Stage 1 (registered on en):
  - s1_sum = sign-extended sum of the masked lanes, computed at ACC_WIDTH.
  - s1_last = in_last; s1_valid = in_valid.
- Stage 2 (on en && s1_valid):
  - If !s1_last: acc <= acc + s1_sum.
  - If s1_last: out_data <= acc + s1_sum; out_valid <= 1; out_row <= row counter; row counter += 1 (wraps at 2^ROW_WIDTH); acc <= 0.
- On en && !(s1_valid && s1_last): out_valid <= 0, but only if out_ready consumed the result. out_data keeps its last value.
- Latency:
  - A last beat accepted at cycle t produces out_valid at t+2 when unstalled.
  - Back-to-back single-beat rows with out_ready held high give one result per cycle.
- Arithmetic: signed wrap modulo 2^ACC_WIDTH (default build).
- Empty row (in_last with in_mask=0 and no prior beats): emits 0 and consumes a row index.
- Beat with in_mask=0 and in_last=0: legal, contributes nothing.
- in_valid=0 cycles: bubbles; the accumulator is untouched.
- Stall: while out_valid && !out_ready, in_ready=0, and out_data and out_row are stable.
- Reset mid-row: the partial accumulation is discarded and the row counter returns to 0.

Optional Feature:
- Macro: SPMV_ROW_REDUCE_SAT_EN.
- Defined: each stage-2 add saturates to the signed ACC_WIDTH bounds, 2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1). Saturation is sticky within the row: once saturated, the row result stays at that bound. This state clears at the row end.
- Undefined: plain two's-complement wrap; no saturation logic is generated.

Test Plan:
- Single row: one beat, in_data={1,2,3,4}, mask=4'hF, last=1, out_ready=1 -> two cycles later out_valid=1, out_data=10, out_row=0.
- Multi-beat row: beats {1,1,1,1}, {-5,0,0,0}, {2,2,0,0} with mask 4'h3 on the last beat, last on the third beat -> out_data=3 (4 - 5 + 4), out_row=0. The next row reports out_row=1.
- Backpressure: hold out_ready=0 after a result, then drive 3 more single-beat rows {1,0,0,0}, {2,0,0,0}, {3,0,0,0} -> in_ready=0 and out_data stable while held. On release, results 1, 2, 3 appear in order with none lost.
- Empty row plus bubbles: last beat with mask=0, then in_valid toggling 1/0 on row {7,7,7,7} last -> results 0 then 28, out_row 0 then 1.
- Reset mid-row: accept beat {10,10,10,10} last=0, assert rst_n=0 for 1 cycle, then send {1,0,0,0} last=1 -> out_data=1, out_row=0.
- Wrap or saturate:
  - With ACC_WIDTH=72, feed two beats of four lanes each at 2^63-1, last on the second.
  - Expected result 8*(2^63-1); this fits in 72 bits, so the check is an exact sum.
  - Set ACC_WIDTH=66 and repeat. Without the macro, expect the sum wrapped modulo 2^66. With SPMV_ROW_REDUCE_SAT_EN, expect 2^65-1.

Source files
------------

// File: rtl/spmv_row_reduce.sv
// spmv_row_reduce: lane adder tree + row accumulator for SpMV dot products.
// Optional: SPMV_ROW_REDUCE_SAT_EN enables sticky signed saturation of row sums.
module spmv_row_reduce #(
  parameter int DATA_WIDTH  = 64,
  parameter int PARALLELISM = 4,
  parameter int ACC_WIDTH   = 72,
  parameter int ROW_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [PARALLELISM],
  input  logic [PARALLELISM-1:0] in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [ROW_WIDTH-1:0]  out_row
);

  logic                 en;
  logic [ACC_WIDTH-1:0] lane_sum;
  logic [ACC_WIDTH-1:0] s1_sum;
  logic                 s1_valid;
  logic                 s1_last;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] nxt;
  logic [ROW_WIDTH-1:0] row_cnt;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      if (in_mask[i])
        lane_sum = lane_sum + ACC_WIDTH'($signed(in_data[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_sum   <= lane_sum;
    end
  end

`ifdef SPMV_ROW_REDUCE_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wide;
  logic               ovf;
  logic               sat_q;

  assign wide = {acc[ACC_WIDTH-1], acc}
              + {s1_sum[ACC_WIDTH-1], s1_sum};
  assign ovf  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];

  // Once a row has clipped, acc holds the bound and stays there.
  always_comb begin
    nxt = wide[ACC_WIDTH-1:0];
    if (sat_q)
      nxt = acc;
    else if (ovf)
      nxt = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_q <= 1'b0;
    else if (en && s1_valid)
      sat_q <= s1_last ? 1'b0 : (sat_q | ovf);
  end
`else
  assign nxt = acc + s1_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else if (en) begin
      if (s1_valid && s1_last) begin
        out_data  <= nxt;
        out_valid <= 1'b1;
        out_row   <= row_cnt;
        row_cnt   <= row_cnt + ROW_WIDTH'(1);
        acc       <= '0;
      end else begin
        out_valid <= 1'b0;
        if (s1_valid)
          acc <= nxt;
      end
    end
  end

endmodule
